// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline-control types for the 5-stage core
//   hc_state_t  : hazard-unit sequencer states
//   pipe_ctrl_t : PC enable plus enable/flush of each pipeline latch
//   run_ctrl()  : branch / load-use / instruction-miss resolution (no halt, no data miss)
package cpu_types_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} hc_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_fl;
    logic idex_en;
    logic idex_fl;
    logic exmem_en;
    logic exmem_fl;
    logic memwb_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_DEFAULT = pipe_ctrl_t'(8'b1101_0101);
  localparam pipe_ctrl_t CTRL_FREEZE  = pipe_ctrl_t'(8'b0000_0000);
  localparam pipe_ctrl_t CTRL_HALT    = pipe_ctrl_t'(8'b0111_1111);

  // Rules shared by RUN (after halt/data-miss checks) and the DWAIT exit cycle.
  function automatic pipe_ctrl_t run_ctrl(input logic br, input logic ih, input logic lu);
    pipe_ctrl_t c;
    c = CTRL_DEFAULT;
    if (br && ih) begin
      c.ifid_fl = 1'b1;
      c.idex_fl = 1'b1;
    end else if (br) begin
      // hold the branch in EX until the redirected fetch lands; bubble into MEM
      c.pc_en    = 1'b0;
      c.ifid_en  = 1'b0;
      c.idex_en  = 1'b0;
      c.exmem_fl = 1'b1;
    end else if (lu) begin
      c.pc_en   = 1'b0;
      c.ifid_en = 1'b0;
      c.idex_fl = 1'b1;
    end else if (!ih) begin
      c.pc_en   = 1'b0;
      c.ifid_fl = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the ID instruction
//   memtoReg_EX_i : EX instruction is a load
//   rd_EX_i       : EX destination register
//   rs_ID_i/rt_ID_i : ID source registers
//   load_use_o    : stall required
module load_use_detect #(
  parameter int REGW = 5
) (
  input  logic            memtoReg_EX_i,
  input  logic [REGW-1:0] rd_EX_i,
  input  logic [REGW-1:0] rs_ID_i,
  input  logic [REGW-1:0] rt_ID_i,
  output logic            load_use_o
);

  // r0 is hardwired zero, so a load targeting it never creates a dependence
  assign load_use_o = memtoReg_EX_i && (rd_EX_i != '0) && (rd_EX_i == rs_ID_i || rd_EX_i == rt_ID_i);

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline sequencer driving PC enable and latch enable/flush pairs
//   CLK, nRST            : clock, async active-low reset
//   ihit, dhit           : fetch / data access complete
//   mem_req_MEM, halt_MEM: MEM-stage memory request and halt
//   branch_taken_EX      : EX redirect
//   memtoReg_EX, rd_EX, rs_ID, rt_ID : load-use inputs
//   pc_en, *_enable, *_flush : latch controls (flush wins inside each latch)
//   halted, stall_count  : registered status
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_req_MEM,
  input  logic            halt_MEM,
  input  logic            branch_taken_EX,
  input  logic            memtoReg_EX,
  input  logic [REGW-1:0] rd_EX,
  input  logic [REGW-1:0] rs_ID,
  input  logic [REGW-1:0] rt_ID,
  output logic            pc_en,
  output logic            ifid_enable,
  output logic            ifid_flush,
  output logic            idex_enable,
  output logic            idex_flush,
  output logic            exmem_enable,
  output logic            exmem_flush,
  output logic            memwb_enable,
  output logic            halted,
  output logic [CNTW-1:0] stall_count
);

  hc_state_t       state_q, state_d;
  pipe_ctrl_t      ctrl;
  logic            load_use;
  logic            halted_q;
  logic [CNTW-1:0] cnt_q;

  load_use_detect #(.REGW(REGW)) u_lud (
    .memtoReg_EX_i(memtoReg_EX),
    .rd_EX_i      (rd_EX),
    .rs_ID_i      (rs_ID),
    .rt_ID_i      (rt_ID),
    .load_use_o   (load_use)
  );

  always_comb begin
    ctrl    = CTRL_DEFAULT;
    state_d = state_q;
    case (state_q)
      RUN:
        if (halt_MEM) begin
          ctrl    = CTRL_HALT;
          state_d = HALTED;
        end else if (mem_req_MEM && !dhit) begin
          ctrl    = CTRL_FREEZE;
          state_d = DWAIT;
        end else ctrl = run_ctrl(branch_taken_EX, ihit, load_use);
      DWAIT:
        if (dhit) begin
          ctrl    = run_ctrl(branch_taken_EX, ihit, load_use);
          state_d = RUN;
        end else ctrl = CTRL_FREEZE;
      default: ctrl = CTRL_FREEZE;
    endcase
    // keep every latch quiet while reset is asserted
    if (!nRST) ctrl = CTRL_FREEZE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= state_d == HALTED;
      if (!ctrl.pc_en && state_q != HALTED && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_enable  = ctrl.ifid_en;
  assign ifid_flush   = ctrl.ifid_fl;
  assign idex_enable  = ctrl.idex_en;
  assign idex_flush   = ctrl.idex_fl;
  assign exmem_enable = ctrl.exmem_en;
  assign exmem_flush  = ctrl.exmem_fl;
  assign memwb_enable = ctrl.memwb_en;
  assign halted       = halted_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam int REGW = 5;
  localparam int CNTW = 4;

  // packed view {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en}
  localparam logic [7:0] C_DEF  = 8'b1101_0101;
  localparam logic [7:0] C_OFF  = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b0001_1101;
  localparam logic [7:0] C_BRH  = 8'b1111_1101;
  localparam logic [7:0] C_BRM  = 8'b0000_0111;
  localparam logic [7:0] C_HALT = 8'b0111_1111;
  localparam logic [7:0] C_IMIS = 8'b0111_0101;

  logic            CLK = 1'b0, nRST = 1'b0;
  logic            ihit = 1'b1, dhit = 1'b0, mem_req_MEM = 1'b0, halt_MEM = 1'b0;
  logic            branch_taken_EX = 1'b0, memtoReg_EX = 1'b0;
  logic [REGW-1:0] rd_EX = '0, rs_ID = '0, rt_ID = '0;
  logic            pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic            exmem_enable, exmem_flush, memwb_enable, halted;
  logic [CNTW-1:0] stall_count;
  logic [7:0]      ctl;
  int              total = 0, bad = 0;

  hazard_control_unit #(.REGW(REGW), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req_MEM(mem_req_MEM),
    .halt_MEM(halt_MEM), .branch_taken_EX(branch_taken_EX), .memtoReg_EX(memtoReg_EX),
    .rd_EX(rd_EX), .rs_ID(rs_ID), .rt_ID(rt_ID), .pc_en(pc_en),
    .ifid_enable(ifid_enable), .ifid_flush(ifid_flush), .idex_enable(idex_enable),
    .idex_flush(idex_flush), .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .halted(halted), .stall_count(stall_count)
  );

  assign ctl = {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable, exmem_flush, memwb_enable};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [7:0] c, input logic h, input int n);
    #1;
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".cnt"}, 32'(stall_count), 32'(n));
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    ihit = 1'b1; dhit = 1'b0; mem_req_MEM = 1'b0; halt_MEM = 1'b0;
    branch_taken_EX = 1'b0; memtoReg_EX = 1'b0; rd_EX = '0; rs_ID = '0; rt_ID = '0;
  endtask

  initial begin
    #2 look("reset", C_OFF, 1'b0, 0);
    tick; tick;
    nRST = 1'b1;
    look("run_idle", C_DEF, 1'b0, 0);
    memtoReg_EX = 1'b1; rd_EX = 5'd5; rs_ID = 5'd5;
    look("lu_rs", C_LU, 1'b0, 0);
    tick; memtoReg_EX = 1'b0;
    look("lu_after", C_DEF, 1'b0, 1);
    memtoReg_EX = 1'b1; rd_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
    look("lu_r0", C_DEF, 1'b0, 1);
    rd_EX = 5'd7; rt_ID = 5'd7; rs_ID = 5'd3;
    look("lu_rt", C_LU, 1'b0, 1);
    tick; idle;
    mem_req_MEM = 1'b1;
    look("dmiss0", C_OFF, 1'b0, 2);
    tick; look("dmiss1", C_OFF, 1'b0, 3);
    tick; look("dmiss2", C_OFF, 1'b0, 4);
    tick; dhit = 1'b1;
    look("dhit", C_DEF, 1'b0, 5);
    tick; idle;
    look("dwait_exit", C_DEF, 1'b0, 5);
    mem_req_MEM = 1'b1;
    look("dmiss_b", C_OFF, 1'b0, 5);
    tick; dhit = 1'b1; ihit = 1'b0;
    look("dhit_imiss", C_IMIS, 1'b0, 6);
    tick; idle;
    look("dwait_exit_b", C_DEF, 1'b0, 7);
    branch_taken_EX = 1'b1; ihit = 1'b0;
    look("br_imiss", C_BRM, 1'b0, 7);
    tick; ihit = 1'b1;
    look("br_ihit", C_BRH, 1'b0, 8);
    tick; memtoReg_EX = 1'b1; rd_EX = 5'd5; rs_ID = 5'd5;
    look("br_lu", C_BRH, 1'b0, 8);
    tick; idle; ihit = 1'b0;
    look("imiss", C_IMIS, 1'b0, 8);
    tick; idle;
    halt_MEM = 1'b1; mem_req_MEM = 1'b1;
    look("halt", C_HALT, 1'b0, 9);
    tick; idle;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; branch_taken_EX = i[1];
      look($sformatf("halted%0d", i), C_OFF, 1'b1, 10);
      tick;
    end
    idle;
    nRST = 1'b0;
    look("halt_rst", C_OFF, 1'b0, 0);
    #3 nRST = 1'b1;
    look("post_halt_rst", C_DEF, 1'b0, 0);
    mem_req_MEM = 1'b1;
    tick; nRST = 1'b0;
    look("dwait_rst", C_OFF, 1'b0, 0);
    #3 nRST = 1'b1; idle;
    look("post_dwait_rst", C_DEF, 1'b0, 0);
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    look("saturate", C_IMIS, 1'b0, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
